vote_seq_ctrl: RTL
==================

Name: vote_seq_ctrl

Overview:
- Sequential controller that collects one-hot ballots from N_VOTERS voters one at a time over a valid/ready handshake.
- Rejects malformed ballots, keeps a per-candidate tally, and decides the winner once the ballot set is complete.
- Presents the result on a valid/ready output handshake.
- Sits in front of the 3-candidate voting datapath: the datapath is a one-shot combinational vote; this block time-multiplexes a single ballot input and sequences the decision.

Parameters:
- N_VOTERS, 5, number of accepted (well-formed) ballots required before a decision; legal range 1..7.
- CNT_W, 3, width of each tally counter, ballot counter and invalid counter; must satisfy 2^CNT_W > N_VOTERS.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that opens a new election; honoured only in IDLE.
- ballot  input  3  candidate vote, one-hot: 100 = A, 010 = B, 001 = C.
- ballot_valid  input  1  ballot is presented this cycle.
- ballot_ready  output  1  block accepts a ballot this cycle.
- res_valid  output  1  winner/tie are valid and held.
- res_ready  input  1  consumer takes the result.
- winner  output  3  one-hot winning candidate; 000 on tie.
- tie  output  1  top count shared by two or more candidates.
- invalid_cnt  output  CNT_W  malformed ballots rejected in the current election; saturating.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst = 1 at a clock edge):
  - state goes to IDLE.
  - All tallies, the ballot counter and invalid_cnt clear to 0.
  - ballot_ready = 0, res_valid = 0, winner = 000, tie = 0, busy = 0.
  - Reset overrides every other input, including mid-election and mid-result; partial tallies are discarded.
- States: IDLE, COLLECT, DECIDE, RESULT.
- IDLE:
  - ballot_ready = 0.
  - On start = 1: clear tallies, ballot counter and invalid_cnt; next state is COLLECT.
  - winner and tie retain their last values but res_valid = 0.
- COLLECT:
  - ballot_ready = 1.
  - A transfer occurs on ballot_valid & ballot_ready.
  - On a transfer with ballot exactly one-hot: the matching tally increments by 1 and the ballot counter increments by 1.
  - On a transfer with any other pattern (000, 011, 101, 110, 111): the ballot is consumed, no tally changes, the ballot counter is unchanged, and invalid_cnt increments, saturating at 2^CNT_W - 1.
  - When the accepted transfer brings the ballot counter to N_VOTERS, the next state is DECIDE. ballot_ready is low from the following cycle onward.
  - start is ignored in COLLECT.
- DECIDE (exactly one cycle):
  - ballot_ready = 0.
  - Compare the three tallies; the maximum count M is computed at CNT_W bits, unsigned.
  - If exactly one candidate has count M: winner = that candidate's one-hot code, tie = 0.
  - Otherwise: winner = 000, tie = 1.
  - winner and tie are registered at the end of DECIDE; next state is RESULT.
- RESULT:
  - res_valid = 1; winner, tie and invalid_cnt are held stable.
  - On res_ready = 1 the result is consumed and the next state is IDLE; res_valid drops the next cycle.
  - With res_ready held low, RESULT is held indefinitely.
  - start is ignored.
- Latency:
  - start to first ballot_ready = 1 cycle.
  - Last accepted ballot to res_valid = 2 cycles (DECIDE, then RESULT).
  - Minimum election length = N_VOTERS + 3 cycles, assuming ballot_valid is held high with only valid ballots.

Test Plan:
- Clear majority: start, then ballots 100, 100, 001, 100, 010 → res_valid 2 cycles after the 5th ballot; winner = 100, tie = 0, invalid_cnt = 0.
- Tie: ballots 010, 001, 100, 100, 010 (A = 2, B = 2, C = 1) → winner = 000, tie = 1. Unanimous 001 × 5 → winner = 001, tie = 0.
- Malformed ballots:
  - Sequence 100, 011, 010, 000, 010, 010, 001 → 7 transfers, invalid_cnt = 2, winner = 010, tie = 0.
  - ballot_ready stays high until the 5th well-formed ballot.
- Handshake stalls:
  - ballot_valid toggles low between ballots → tallies unchanged on idle cycles.
  - res_ready held low for 10 cycles → res_valid and winner stable throughout.
  - start asserted during COLLECT or RESULT → ignored.
- Reset mid-operation:
  - rst after 3 ballots → next cycle: busy = 0, ballot_ready = 0, res_valid = 0.
  - New start plus 5 × 100 → winner = 100 with no carry-over from the aborted election.
- Back-to-back elections: res_ready = 1 and start on the following IDLE cycle → second election's invalid_cnt starts at 0 and produces its own result.

Source files
------------

// File: rtl/vote_seq_ctrl.sv
// vote_seq_ctrl
//   Collects one-hot ballots from N_VOTERS voters, one per valid/ready
//   transfer, into three tallies. Malformed ballots are consumed but only
//   counted (saturating) in invalid_cnt. Once the full set of well-formed
//   ballots is in, the winner (or a tie) is decided in one cycle and held
//   on a valid/ready result handshake until the consumer takes it.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start        opens a new election (honoured only in IDLE)
//   ballot       one-hot vote: 100 = A, 010 = B, 001 = C
//   ballot_valid ballot present this cycle
//   ballot_ready block accepts a ballot this cycle
//   res_valid    winner/tie valid and held
//   res_ready    consumer takes the result
//   winner       one-hot winning candidate, 000 on tie
//   tie          top count shared by two or more candidates
//   invalid_cnt  malformed ballots in the current election (saturating)
//   busy         high in any state other than IDLE
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for start; last winner/tie retained, res_valid low
// COLLECT | accepting ballots until N_VOTERS well-formed ones are counted
// DECIDE  | one cycle: compare tallies, register winner/tie
// RESULT  | res_valid high, outputs held until res_ready

module vote_seq_ctrl #(
  parameter int N_VOTERS = 5,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ballot,
  input  logic             ballot_valid,
  output logic             ballot_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [2:0]       winner,
  output logic             tie,
  output logic [CNT_W-1:0] invalid_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DECIDE  = 2'd2,
    RESULT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_VOTERS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  state_t           state_q;
  logic [CNT_W-1:0] tally_a_q, tally_b_q, tally_c_q;
  logic [CNT_W-1:0] nballot_q;
  logic [CNT_W-1:0] invalid_q;
  logic             ready_q;
  logic             res_valid_q;
  logic [2:0]       winner_q;
  logic             tie_q;
  logic             busy_q;

  logic             onehot;
  logic [CNT_W-1:0] max_cnt;
  logic [2:0]       top_hits;
  logic [2:0]       winner_d;
  logic             tie_d;

  assign onehot = (ballot == 3'b100) || (ballot == 3'b010) || (ballot == 3'b001);

  // Decision logic, sampled only in DECIDE.
  always_comb begin
    max_cnt = tally_a_q;
    if (tally_b_q > max_cnt) max_cnt = tally_b_q;
    if (tally_c_q > max_cnt) max_cnt = tally_c_q;
    top_hits = {tally_a_q == max_cnt, tally_b_q == max_cnt, tally_c_q == max_cnt};
    winner_d = 3'b000;
    tie_d    = 1'b1;
    // A single hit is itself the one-hot winner code.
    if (top_hits == 3'b100 || top_hits == 3'b010 || top_hits == 3'b001) begin
      winner_d = top_hits;
      tie_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tally_a_q   <= '0;
      tally_b_q   <= '0;
      tally_c_q   <= '0;
      nballot_q   <= '0;
      invalid_q   <= '0;
      ready_q     <= 1'b0;
      res_valid_q <= 1'b0;
      winner_q    <= 3'b000;
      tie_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            tally_a_q <= '0;
            tally_b_q <= '0;
            tally_c_q <= '0;
            nballot_q <= '0;
            invalid_q <= '0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= COLLECT;
          end
        end
        COLLECT: begin
          if (ballot_valid) begin
            if (onehot) begin
              if (ballot[2]) tally_a_q <= tally_a_q + 1'b1;
              if (ballot[1]) tally_b_q <= tally_b_q + 1'b1;
              if (ballot[0]) tally_c_q <= tally_c_q + 1'b1;
              nballot_q <= nballot_q + 1'b1;
              if (nballot_q == LAST_IDX) begin
                ready_q <= 1'b0;
                state_q <= DECIDE;
              end
            end else if (invalid_q != CNT_MAX) begin
              invalid_q <= invalid_q + 1'b1;
            end
          end
        end
        DECIDE: begin
          winner_q    <= winner_d;
          tie_q       <= tie_d;
          res_valid_q <= 1'b1;
          state_q     <= RESULT;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ballot_ready = ready_q;
  assign res_valid    = res_valid_q;
  assign winner       = winner_q;
  assign tie          = tie_q;
  assign invalid_cnt  = invalid_q;
  assign busy         = busy_q;

endmodule
